led_pattern: RTL and testbench

Consumes the 1 Hz square wave from the 50 MHz → 1 Hz divider and drives an 8-LED pattern that advances once per second. Operates entirely in the 50 MHz `clk` domain. The divided clock is treated as data: it is synchronised and edge-detected, never used as a clock. Four selectable patterns are supported: left chase, right chase, bounce and blink all. A pause input freezes the display.

---
 rtl/led_pattern.sv | 125 ++++++++++++
 tb/tb_led_pattern.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern.sv
// led_pattern: steps an 8-LED pattern once per rising edge of the 1 Hz divider
// output. clk_1hz is sampled as data (synchronised and edge-detected) and is
// never used as a clock. Patterns: left chase, right chase, bounce, blink all.
module led_pattern #(
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [7:0] led,
  output logic       step
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [7:0] LED_MASK = {8{LED_ACTIVE_LOW}};

  logic       s1, s2, s3;
  logic       rise;
  logic       acc;
  mode_e      mode_in;
  mode_e      mode_r, mode_nx;
  logic [2:0] pos, pos_nx;
  logic       dir, dir_nx;
  logic [7:0] pat, pat_nx;

  assign rise    = s2 & ~s3;
  assign acc     = rise & ~pause;
  assign mode_in = mode_e'(mode);

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_1hz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Next pattern state: a mode change only loads the entry state; otherwise advance.
  always_comb begin
    mode_nx = mode_r;
    pos_nx  = pos;
    dir_nx  = dir;
    pat_nx  = pat;
    if (acc) begin
      if (mode_in != mode_r) begin
        mode_nx = mode_in;
        case (mode_in)
          MODE_LEFT: begin
            pos_nx = 3'd0;
            pat_nx = 8'h01;
          end
          MODE_RIGHT: begin
            pos_nx = 3'd7;
            pat_nx = 8'h80;
          end
          MODE_BOUNCE: begin
            pos_nx = 3'd0;
            dir_nx = 1'b0;
            pat_nx = 8'h01;
          end
          MODE_BLINK: begin
            pat_nx = 8'hFF;
          end
        endcase
      end else begin
        case (mode_r)
          MODE_LEFT: begin
            pos_nx = pos + 3'd1;
            pat_nx = 8'h01 << pos_nx;
          end
          MODE_RIGHT: begin
            pos_nx = pos - 3'd1;
            pat_nx = 8'h01 << pos_nx;
          end
          MODE_BOUNCE: begin
            if (!dir) begin
              pos_nx = pos + 3'd1;
              if (pos_nx == 3'd7) dir_nx = 1'b1;
            end else begin
              pos_nx = pos - 3'd1;
              if (pos_nx == 3'd0) dir_nx = 1'b0;
            end
            pat_nx = 8'h01 << pos_nx;
          end
          MODE_BLINK: begin
            pat_nx = ~pat;
          end
        endcase
      end
    end
  end

  // Pattern state and registered outputs; led tracks pat_nx so both update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_LEFT;
      pos    <= 3'd0;
      dir    <= 1'b0;
      pat    <= 8'h01;
      led    <= 8'h01 ^ LED_MASK;
      step   <= 1'b0;
    end else begin
      mode_r <= mode_nx;
      pos    <= pos_nx;
      dir    <= dir_nx;
      pat    <= pat_nx;
      led    <= pat_nx ^ LED_MASK;
      step   <= acc;
    end
  end

endmodule

// File: tb/tb_led_pattern.sv
// Bench for led_pattern: table of per-edge vectors with a scoreboard queue
// checked whenever step fires, plus hand-written reset sequences.
module tb_led_pattern;

  logic       clk;
  logic       rst_n;
  logic       clk_1hz;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] led_a, led_b;
  logic       step_a, step_b;

  led_pattern #(.LED_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .mode(mode),
    .pause(pause), .led(led_a), .step(step_a)
  );

  led_pattern #(.LED_ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .mode(mode),
    .pause(pause), .led(led_b), .step(step_b)
  );

  typedef struct {
    logic [1:0] mode;
    logic       pause;
    logic       glitch;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  exp;
    int unsigned due;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  prev_led = 8'h00;
  int unsigned n_pre;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic p, input logic g, input logic [7:0] e);
    vec_t v;
    v.mode = m; v.pause = p; v.glitch = g; v.exp = e;
    vecs.push_back(v);
  endtask

  // Scoreboard monitor: every step must match a pushed edge, on time, with the right LEDs.
  always @(negedge clk) begin
    sb_t it;
    if (mon_en && rst_n) begin
      if (step_a) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step got step=1 expected step=0 at cycle %0d", cyc);
        end else begin
          it = sb.pop_front();
          chk8("led_on_step", led_a, it.exp);
          chk8("led_active_low_on_step", led_b, ~it.exp);
          chk8("step_active_low_build", {7'd0, step_b}, 8'd1);
          checks++;
          if (cyc != it.due) begin
            errors++;
            $display("FAIL step_latency got cycle %0d expected cycle %0d", cyc, it.due);
          end
        end
      end else begin
        chk8("led_hold_without_step", led_a, prev_led);
        chk8("step_active_low_idle", {7'd0, step_b}, 8'd0);
      end
    end
    prev_led = led_a;
  end

  task automatic run_vec(input vec_t v);
    sb_t it;
    mode  = v.mode;
    pause = v.pause;
    repeat (4) @(negedge clk);
    if (v.glitch) begin
      mode = v.mode ^ 2'b01;
      repeat (3) @(negedge clk);
      mode = v.mode;
      repeat (2) @(negedge clk);
    end
    clk_1hz = 1'b1;
    if (!v.pause) begin
      it.exp = v.exp;
      it.due = cyc + 3;
      sb.push_back(it);
    end
    repeat (10) @(negedge clk);
    clk_1hz = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_step got %0d pending expected 0 pending", sb.size());
      sb.delete();
    end
    chk8("led_after_period", led_a, v.exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Left chase from reset state
    add(2'd0, 1'b0, 1'b0, 8'h02); add(2'd0, 1'b0, 1'b0, 8'h04);
    add(2'd0, 1'b0, 1'b0, 8'h08); add(2'd0, 1'b0, 1'b0, 8'h10);
    add(2'd0, 1'b0, 1'b0, 8'h20); add(2'd0, 1'b0, 1'b0, 8'h40);
    add(2'd0, 1'b0, 1'b0, 8'h80); add(2'd0, 1'b0, 1'b0, 8'h01);
    add(2'd0, 1'b0, 1'b0, 8'h02);
    // Right chase: entry then full wrap
    add(2'd1, 1'b0, 1'b0, 8'h80); add(2'd1, 1'b0, 1'b0, 8'h40);
    add(2'd1, 1'b0, 1'b0, 8'h20); add(2'd1, 1'b0, 1'b0, 8'h10);
    add(2'd1, 1'b0, 1'b0, 8'h08); add(2'd1, 1'b0, 1'b0, 8'h04);
    add(2'd1, 1'b0, 1'b0, 8'h02); add(2'd1, 1'b0, 1'b0, 8'h01);
    add(2'd1, 1'b0, 1'b0, 8'h80);
    // Bounce: entry then 16 steps
    add(2'd2, 1'b0, 1'b0, 8'h01);
    add(2'd2, 1'b0, 1'b0, 8'h02); add(2'd2, 1'b0, 1'b0, 8'h04);
    add(2'd2, 1'b0, 1'b0, 8'h08); add(2'd2, 1'b0, 1'b0, 8'h10);
    add(2'd2, 1'b0, 1'b0, 8'h20); add(2'd2, 1'b0, 1'b0, 8'h40);
    add(2'd2, 1'b0, 1'b0, 8'h80); add(2'd2, 1'b0, 1'b0, 8'h40);
    add(2'd2, 1'b0, 1'b0, 8'h20); add(2'd2, 1'b0, 1'b0, 8'h10);
    add(2'd2, 1'b0, 1'b0, 8'h08); add(2'd2, 1'b0, 1'b0, 8'h04);
    add(2'd2, 1'b0, 1'b0, 8'h02); add(2'd2, 1'b0, 1'b0, 8'h01);
    add(2'd2, 1'b0, 1'b0, 8'h02); add(2'd2, 1'b0, 1'b0, 8'h04);
    // Blink, paused edges, release, mode glitch between edges
    add(2'd3, 1'b0, 1'b0, 8'hFF); add(2'd3, 1'b0, 1'b0, 8'h00);
    add(2'd3, 1'b0, 1'b0, 8'hFF);
    add(2'd3, 1'b1, 1'b0, 8'hFF); add(2'd3, 1'b1, 1'b0, 8'hFF);
    add(2'd3, 1'b1, 1'b0, 8'hFF);
    add(2'd3, 1'b0, 1'b0, 8'h00); add(2'd3, 1'b0, 1'b0, 8'hFF);
    add(2'd3, 1'b0, 1'b1, 8'h00);
    n_pre = vecs.size();
    // After mid-run reset: mode_r=0, pos=0, so left chase advances to 02
    add(2'd0, 1'b0, 1'b0, 8'h02); add(2'd0, 1'b0, 1'b1, 8'h04);
    add(2'd1, 1'b0, 1'b1, 8'h80); add(2'd1, 1'b0, 1'b0, 8'h40);

    rst_n   = 1'b0;
    clk_1hz = 1'b0;
    mode    = 2'd0;
    pause   = 1'b0;
    repeat (3) @(negedge clk);
    chk8("reset_led", led_a, 8'h01);
    chk8("reset_led_active_low", led_b, 8'hFE);
    chk8("reset_step", {7'd0, step_a}, 8'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < int'(n_pre); i++) run_vec(vecs[i]);

    // Asynchronous reset while a step pulse is high
    mon_en = 1'b0;
    mode   = 2'd3;
    pause  = 1'b0;
    @(negedge clk);
    clk_1hz = 1'b1;
    repeat (3) @(negedge clk);
    chk8("step_before_async_reset", {7'd0, step_a}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk8("async_reset_led", led_a, 8'h01);
    chk8("async_reset_led_active_low", led_b, 8'hFE);
    chk8("async_reset_step", {7'd0, step_a}, 8'd0);
    clk_1hz = 1'b0;
    repeat (3) @(negedge clk);
    chk8("held_reset_led", led_a, 8'h01);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    mon_en = 1'b1;

    for (int i = int'(n_pre); i < vecs.size(); i++) run_vec(vecs[i]);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
